fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 imem_req  out  1  instruction-memory read request.
REQ-006 imem_addr  out  32  fetch address; equals pc.
REQ-007 imem_ack  in  1  read data valid this cycle.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 instr_valid  out  1  held instruction valid for decode/execute.
REQ-010 instr  out  32  held instruction word.
REQ-011 op_code  out  7  instr[6:0], feeds control unit.
REQ-012 func3  out  3  instr[14:12].
REQ-013 func7  out  7  instr[31:25].
REQ-014 pc  out  32  address of held instruction.
REQ-015 pc_plus4  out  32  pc+4, link value for JAL/JALR write-back.
REQ-016 retire  in  1  execute stage has consumed the instruction; next-PC inputs valid.
REQ-017 branch  in  3  control-unit branch code: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JALR, 110 JAL, 111 none.
REQ-018 jump  in  1  control-unit jump flag; treated identically to branch=101.
REQ-019 alu_zero  in  1  ALU result zero.
REQ-020 alu_lt  in  1  ALU signed less-than.
REQ-021 imm  in  32  sign-extended branch/JAL offset.
REQ-022 alu_result  in  32  JALR target (rs1+imm).
REQ-023 misalign_err  out  1  sticky misaligned-target flag.

Function
REQ-024 FSM states SHALL be IDLE, REQ, HOLD, HALT.
REQ-025 IDLE: one cycle after reset release, imem_req=0, then -> REQ.
REQ-026 REQ: imem_req=1, imem_addr=pc; imem_ack=1 captures imem_rdata into instr and -> HOLD; ack may occur in the first REQ cycle.
REQ-027 HOLD: instr_valid=1, imem_req=0; retire=1 loads next PC, -> REQ on next cycle.
REQ-028 Fetch latency: ack in cycle N SHALL give instr_valid=1 in cycle N+1; retire in cycle M SHALL give imem_req=1 with new address in cycle M+1.
REQ-029 Next PC: taken branch/JAL = pc+imm; JALR (branch=101 or jump=1) = alu_result with bit0 cleared; BEQ taken on alu_zero, BNE on !alu_zero, BLT on alu_lt, BGE on !alu_lt; otherwise pc+4.
REQ-030 All PC arithmetic SHALL be modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
REQ-031 Next PC with bit1 set SHALL set misalign_err, leave pc unchanged, enter HALT.
REQ-032 HALT: imem_req=0, instr_valid=0, all inputs ignored until reset.
REQ-033 imem_ack outside REQ SHALL be ignored; retire outside HOLD SHALL be ignored.
REQ-034 op_code/func3/func7/pc_plus4 SHALL be combinational slices of instr/pc.

Reset
REQ-035 Reset SHALL force: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, misalign_err=0.
REQ-036 Reset asserted mid-REQ or mid-HOLD SHALL abort the access; a late ack after release arrives in IDLE and is discarded.

Structure
REQ-037 Shared package SHALL hold FSM state encoding, branch-code constants (BR_NONE..BR_JAL), NOP constant, and default RESET_PC.
REQ-038 Next-PC computation SHALL be a combinational sub-module next_pc_calc; FSM and registers remain in fetch_pc_unit.

Verification
REQ-039 Reset, ack at first REQ with rdata=0x00500093 -> instr_valid=1 next cycle, op_code=0010011, pc=0x0.
REQ-040 HOLD at pc=0x100, branch=001, alu_zero=1, imm=0x20, retire -> next imem_addr=0x120; alu_zero=0 -> 0x104.
REQ-041 branch=101, alu_result=0x2001, retire -> imem_addr=0x2000; pc_plus4 before retire = pc+4.
REQ-042 pc=0xFFFF_FFFC, branch=000, retire -> imem_addr=0x0000_0000.
REQ-043 branch=110, pc=0x100, imm=0x6 -> misalign_err=1, pc stays 0x100, imem_req stays 0 until rst_n.
REQ-044 rst_n pulsed low during REQ, ack arriving in IDLE -> instr stays NOP, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC unit: FSM encoding, branch codes, NOP and reset PC.
package fetch_pc_unit_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StReq  = 2'b01,
      StHold = 2'b10,
      StHalt = 2'b11
   } fetch_state_e;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_BLT  = 3'b011;
   localparam logic [2:0] BR_BGE  = 3'b100;
   localparam logic [2:0] BR_JALR = 3'b101;
   localparam logic [2:0] BR_JAL  = 3'b110;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Only word alignment of bit 1 is enforced; JALR targets have bit 0 cleared already.
   function automatic logic target_misaligned(input logic [31:0] target);
      return target[1];
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory read port: fetch unit drives request/address, memory returns ack/data.
interface fetch_pc_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection from the control unit's branch code and ALU flags.
module next_pc_calc
   import fetch_pc_unit_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [2:0]  branch_i,
   input  logic        jump_i,
   input  logic        alu_zero_i,
   input  logic        alu_lt_i,
   input  logic [31:0] imm_i,
   input  logic [31:0] alu_result_i,
   output logic [31:0] next_pc_o,
   output logic        misaligned_o
);

   logic [31:0] seq_pc;
   logic [31:0] rel_pc;

   always_comb begin
      seq_pc    = pc_i + 32'd4;
      rel_pc    = pc_i + imm_i;
      next_pc_o = seq_pc;
      if (jump_i || (branch_i == BR_JALR)) begin
         next_pc_o = {alu_result_i[31:1], 1'b0};
      end else begin
         case (branch_i)
            BR_BEQ:  next_pc_o = alu_zero_i ? rel_pc : seq_pc;
            BR_BNE:  next_pc_o = alu_zero_i ? seq_pc : rel_pc;
            BR_BLT:  next_pc_o = alu_lt_i ? rel_pc : seq_pc;
            BR_BGE:  next_pc_o = alu_lt_i ? seq_pc : rel_pc;
            BR_JAL:  next_pc_o = rel_pc;
            default: next_pc_o = seq_pc;
         endcase
      end
      misaligned_o = target_misaligned(next_pc_o);
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch FSM and PC register: requests one instruction, holds it until retired, then steers the PC.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic             clk,
   input  logic             rst_n,
   fetch_pc_unit_if.master  imem,
   output logic             instr_valid,
   output logic [31:0]      instr,
   output logic [6:0]       op_code,
   output logic [2:0]       func3,
   output logic [6:0]       func7,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   input  logic             retire,
   input  logic [2:0]       branch,
   input  logic             jump,
   input  logic             alu_zero,
   input  logic             alu_lt,
   input  logic [31:0]      imm,
   input  logic [31:0]      alu_result,
   output logic             misalign_err
);

   fetch_state_e state_d, state_q;
   logic [31:0]  pc_d, pc_q;
   logic [31:0]  instr_d, instr_q;
   logic         instr_valid_d, instr_valid_q;
   logic         req_d, req_q;
   logic         misalign_d, misalign_q;
   logic [31:0]  next_pc;
   logic         next_misaligned;

   next_pc_calc u_next_pc_calc (
      .pc_i         (pc_q),
      .branch_i     (branch),
      .jump_i       (jump),
      .alu_zero_i   (alu_zero),
      .alu_lt_i     (alu_lt),
      .imm_i        (imm),
      .alu_result_i (alu_result),
      .next_pc_o    (next_pc),
      .misaligned_o (next_misaligned)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      req_d         = req_q;
      misalign_d    = misalign_q;
      case (state_q)
         StIdle: begin
            state_d = StReq;
            req_d   = 1'b1;
         end
         StReq: begin
            if (imem.ack) begin
               instr_d       = imem.rdata;
               instr_valid_d = 1'b1;
               req_d         = 1'b0;
               state_d       = StHold;
            end
         end
         StHold: begin
            if (retire) begin
               instr_valid_d = 1'b0;
               // A bad target freezes the PC at the offending instruction for debug.
               if (next_misaligned) begin
                  misalign_d = 1'b1;
                  state_d    = StHalt;
               end else begin
                  pc_d    = next_pc;
                  req_d   = 1'b1;
                  state_d = StReq;
               end
            end
         end
         StHalt: begin
            req_d         = 1'b0;
            instr_valid_d = 1'b0;
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         pc_q          <= RESET_PC;
         instr_q       <= NOP_INSTR;
         instr_valid_q <= 1'b0;
         req_q         <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         req_q         <= req_d;
         misalign_q    <= misalign_d;
      end
   end

   assign imem.req     = req_q;
   assign imem.addr    = pc_q;
   assign instr_valid  = instr_valid_q;
   assign instr        = instr_q;
   assign op_code      = instr_q[6:0];
   assign func3        = instr_q[14:12];
   assign func7        = instr_q[31:25];
   assign pc           = pc_q;
   assign pc_plus4     = pc_q + 32'd4;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: next-PC vector table plus reset/halt corner sequences.
module tb_fetch_pc_unit;
   import fetch_pc_unit_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic [6:0]  op_code;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire;
   logic [2:0]  branch;
   logic        jump;
   logic        alu_zero;
   logic        alu_lt;
   logic [31:0] imm;
   logic [31:0] alu_result;
   logic        misalign_err;

   fetch_pc_unit_if imem_bus ();

   fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (imem_bus.master),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .op_code      (op_code),
      .func3        (func3),
      .func7        (func7),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .retire       (retire),
      .branch       (branch),
      .jump         (jump),
      .alu_zero     (alu_zero),
      .alu_lt       (alu_lt),
      .imm          (imm),
      .alu_result   (alu_result),
      .misalign_err (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] start_pc;
      logic [2:0]  br;
      logic        jmp;
      logic        z;
      logic        lt;
      logic [31:0] immv;
      logic [31:0] alu;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [14];
   logic [31:0] exp_addr_q [$];
   logic [31:0] cur_pc;
   int          checks;
   int          failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_ctrl();
      retire     = 1'b0;
      branch     = BR_NONE;
      jump       = 1'b0;
      alu_zero   = 1'b0;
      alu_lt     = 1'b0;
      imm        = 32'h0;
      alu_result = 32'h0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_bus.req) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("req_timeout", 32'h0, 32'h1);
   endtask

   // Pops the scoreboard when the request appears, then answers it.
   task automatic do_fetch(input logic [31:0] rdata);
      bit          ok;
      logic [31:0] exp;
      wait_req(ok);
      if (ok) begin
         if (exp_addr_q.size() == 0) begin
            chk("sb_underflow", 32'h1, 32'h0);
         end else begin
            exp = exp_addr_q.pop_front();
            chk("fetch_addr", imem_bus.addr, exp);
         end
         imem_bus.ack   = 1'b1;
         imem_bus.rdata = rdata;
         @(posedge clk);
         #1 imem_bus.ack = 1'b0;
         @(negedge clk);
         chk("instr_valid", {31'h0, instr_valid}, 32'h1);
         chk("instr", instr, rdata);
         chk("pc", pc, cur_pc);
         chk("pc_plus4", pc_plus4, cur_pc + 32'd4);
      end
   endtask

   task automatic retire_with(input logic [2:0] br, input logic jmp, input logic z,
                              input logic lt, input logic [31:0] immv,
                              input logic [31:0] alu, input logic [31:0] exp);
      retire     = 1'b1;
      branch     = br;
      jump       = jmp;
      alu_zero   = z;
      alu_lt     = lt;
      imm        = immv;
      alu_result = alu;
      exp_addr_q.push_back(exp);
      @(posedge clk);
      #1 clear_ctrl();
      @(negedge clk);
      chk("retire_latency", {31'h0, imem_bus.req}, 32'h1);
      cur_pc = exp;
   endtask

   task automatic goto_pc(input logic [31:0] target);
      if (cur_pc != target) begin
         retire_with(BR_NONE, 1'b1, 1'b0, 1'b0, 32'h0, target, target);
         do_fetch(32'h0000_0013);
      end
   endtask

   initial begin
      logic [31:0] exp;
      checks   = 0;
      failures = 0;
      cur_pc   = RST_PC;
      vecs[0]  = '{32'h0000_0100, BR_BEQ,  1'b0, 1'b1, 1'b0, 32'h20,        32'h0, 32'h0000_0120};
      vecs[1]  = '{32'h0000_0100, BR_BEQ,  1'b0, 1'b0, 1'b0, 32'h20,        32'h0, 32'h0000_0104};
      vecs[2]  = '{32'h0000_0100, BR_BNE,  1'b0, 1'b0, 1'b0, 32'h40,        32'h0, 32'h0000_0140};
      vecs[3]  = '{32'h0000_0100, BR_BNE,  1'b0, 1'b1, 1'b0, 32'h40,        32'h0, 32'h0000_0104};
      vecs[4]  = '{32'h0000_0200, BR_BLT,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h0000_01F0};
      vecs[5]  = '{32'h0000_0200, BR_BLT,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0000_0204};
      vecs[6]  = '{32'h0000_0200, BR_BGE,  1'b0, 1'b0, 1'b0, 32'h8,         32'h0, 32'h0000_0208};
      vecs[7]  = '{32'h0000_0200, BR_BGE,  1'b0, 1'b0, 1'b1, 32'h8,         32'h0, 32'h0000_0204};
      vecs[8]  = '{32'h0000_0300, BR_JALR, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_2001, 32'h0000_2000};
      vecs[9]  = '{32'h0000_0300, BR_NONE, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_4005, 32'h0000_4004};
      vecs[10] = '{32'h0000_0300, BR_JAL,  1'b0, 1'b0, 1'b0, 32'h1000,      32'h0, 32'h0000_1300};
      vecs[11] = '{32'h0000_0300, 3'b111,  1'b0, 1'b1, 1'b1, 32'h1000,      32'h0, 32'h0000_0304};
      vecs[12] = '{32'hFFFF_FFFC, BR_NONE, 1'b0, 1'b0, 1'b0, 32'h1000,      32'h0, 32'h0000_0000};
      vecs[13] = '{32'hFFFF_FFF0, BR_JAL,  1'b0, 1'b0, 1'b0, 32'h20,        32'h0, 32'h0000_0010};

      rst_n          = 1'b0;
      imem_bus.ack   = 1'b0;
      imem_bus.rdata = 32'h0;
      clear_ctrl();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", {31'h0, imem_bus.req}, 32'h0);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_pc", pc, RST_PC);
      chk("rst_misalign", {31'h0, misalign_err}, 32'h0);

      exp_addr_q.push_back(RST_PC);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_req", {31'h0, imem_bus.req}, 32'h0);
      do_fetch(32'h0050_0093);
      chk("op_code", {25'h0, op_code}, 32'h13);
      chk("func3", {29'h0, func3}, 32'h0);

      // Ack while holding must not overwrite the held instruction.
      imem_bus.ack   = 1'b1;
      imem_bus.rdata = 32'hBAD0_BAD0;
      @(posedge clk);
      #1 imem_bus.ack = 1'b0;
      @(negedge clk);
      chk("ack_in_hold", instr, 32'h0050_0093);

      retire_with(BR_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
      do_fetch(32'h40B5_0533);
      chk("func7", {25'h0, func7}, 32'h20);
      chk("op_code_r", {25'h0, op_code}, 32'h33);

      for (int i = 0; i < 14; i++) begin
         goto_pc(vecs[i].start_pc);
         chk("vec_pc_plus4", pc_plus4, vecs[i].start_pc + 32'd4);
         retire_with(vecs[i].br, vecs[i].jmp, vecs[i].z, vecs[i].lt, vecs[i].immv,
                     vecs[i].alu, vecs[i].exp);
         do_fetch(32'h0000_0013 | (i << 7));
      end

      // Retire while requesting must be ignored.
      exp = cur_pc + 32'd4;
      retire_with(BR_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, exp);
      retire     = 1'b1;
      jump       = 1'b1;
      alu_result = 32'h0000_5000;
      @(posedge clk);
      #1 clear_ctrl();
      @(negedge clk);
      chk("retire_in_req", imem_bus.addr, exp);
      do_fetch(32'h0000_0013);

      // Reset during REQ, then a late ack in IDLE.
      retire_with(BR_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cur_pc + 32'd4);
      exp = exp_addr_q.pop_front();
      chk("pre_abort_addr", imem_bus.addr, exp);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      imem_bus.ack   = 1'b1;
      imem_bus.rdata = 32'hDEAD_BEEF;
      exp_addr_q.push_back(RST_PC);
      cur_pc = RST_PC;
      @(posedge clk);
      #1 imem_bus.ack = 1'b0;
      @(negedge clk);
      chk("late_ack_instr", instr, NOP_INSTR);
      chk("late_ack_valid", {31'h0, instr_valid}, 32'h0);
      do_fetch(32'h0000_0013);

      // Misaligned JAL target halts with the PC frozen.
      goto_pc(32'h0000_0100);
      retire = 1'b1;
      branch = BR_JAL;
      imm    = 32'h6;
      @(posedge clk);
      #1 clear_ctrl();
      for (int i = 0; i < 4; i++) begin
         imem_bus.ack = 1'b1;
         retire       = 1'b1;
         jump         = 1'b1;
         alu_result   = 32'h0000_0800;
         @(negedge clk);
         chk("halt_req", {31'h0, imem_bus.req}, 32'h0);
         chk("halt_misalign", {31'h0, misalign_err}, 32'h1);
         chk("halt_pc", pc, 32'h0000_0100);
         chk("halt_valid", {31'h0, instr_valid}, 32'h0);
      end
      imem_bus.ack = 1'b0;
      clear_ctrl();
      rst_n = 1'b0;
      @(negedge clk);
      chk("post_halt_rst", {31'h0, misalign_err}, 32'h0);
      chk("sb_empty", exp_addr_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
